reg_renamer: RTL and testbench
==============================

REG_RENAMER -- requirements
Module: reg_renamer

Interface
REQ-001 SHALL have parameter ARCH_REGS, default 32, number of architectural registers; x0 is hardwired zero.
REQ-002 SHALL have parameter PHYS_REGS, default 64, number of physical registers; PHYS_REGS > ARCH_REGS.
REQ-003 SHALL have parameter RET_W, default 2, retire ports per cycle; port 0 is the oldest.
REQ-004 SHALL use derived widths AW=clog2(ARCH_REGS), PW=clog2(PHYS_REGS), FL=PHYS_REGS-ARCH_REGS, CW=clog2(FL)+1.
REQ-005 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have rstn  input  1  synchronous active-low reset.
REQ-007 SHALL have disp_valid  input  1  a dispatch request is present.
REQ-008 SHALL have disp_ready  output  1  the rename is accepted this cycle.
REQ-009 SHALL have sr1, sr2, dr  input  AW each  source and destination architectural registers.
REQ-010 SHALL have dr_wr  input  1  the instruction writes dr (0 for stores, branches and NOP).
REQ-011 SHALL have sr1_p, sr2_p  output  PW each  physical source mappings.
REQ-012 SHALL have dr_p  output  PW  newly allocated physical destination (0 when no allocation).
REQ-013 SHALL have old_dr_p  output  PW  previous mapping of dr; old_vld  output  1  old_dr_p must be freed at retire.
REQ-014 SHALL have ret_valid  input  RET_W  per-port retire strobe.
REQ-015 SHALL have ret_alloc  input  RET_W  the retiring instruction allocated a register.
REQ-016 SHALL have ret_areg  input  RET_W*AW  per-port retiring architectural destination.
REQ-017 SHALL have ret_preg, ret_old  input  RET_W*PW each  per-port retiring new and old physical destinations.
REQ-018 SHALL have flush  input  1  mispredict/exception recovery to committed state.
REQ-019 SHALL have free_cnt  output  CW  number of free physical registers currently held in the free list.

Function
REQ-020 SHALL hold a speculative RAT (spec_rat) and a committed RAT (arch_rat), each ARCH_REGS x PW, plus a circular free list of FL entries with head, tail and commit_head pointers, each CW bits including a wrap bit.
REQ-021 SHALL define alloc = disp_valid & dr_wr & (dr != 0).
REQ-022 SHALL drive disp_ready = ~flush & (~alloc | free_cnt != 0), combinationally.
REQ-023 SHALL drive sr1_p/sr2_p = spec_rat[sr1]/spec_rat[sr2] combinationally in the same cycle, reading the mappings that precede this instruction's own dr update (sr==dr yields the old mapping).
REQ-024 SHALL, when alloc, drive dr_p = free_list[head], old_dr_p = spec_rat[dr] and old_vld = 1; otherwise dr_p = 0, old_dr_p = 0 and old_vld = 0.
REQ-025 SHALL, on a clock edge with disp_valid & disp_ready & alloc, write spec_rat[dr] <= dr_p and advance head by 1; a dispatch with no allocation changes no state.
REQ-026 SHALL, for each retire port k (ascending) with ret_valid[k] & ret_alloc[k], write arch_rat[ret_areg[k]] <= ret_preg[k], write free_list[tail] <= ret_old[k], and advance tail and commit_head by 1 each.
REQ-027 SHALL NOT allocate a register freed on a cycle before the following cycle (no same-cycle retire-to-allocate bypass).
REQ-028 SHALL compute free_cnt = tail - head with modulo-2^CW arithmetic, never exceeding FL.
REQ-029 SHALL, on flush, apply the same-cycle retire first, then set spec_rat <= arch_rat (including this cycle's retire writes) and head <= commit_head (after this cycle's advance), and ignore any dispatch that cycle.
REQ-030 SHALL keep spec_rat[0] = arch_rat[0] = 0, never write x0, and never insert preg 0 into the free list (any ret_old of 0 is ignored).
REQ-031 SHALL make ret_valid with ret_alloc=0 a no-op; when two retires of the same areg occur in one cycle, the higher port wins in arch_rat.

Reset
REQ-032 SHALL, on clk edge with rstn=0, set spec_rat[i] = arch_rat[i] = i, free_list[j] = ARCH_REGS+j, head = commit_head = 0, and tail = FL with the wrap bit set, giving free_cnt = FL.
REQ-033 SHALL, during reset, hold disp_ready = 0, and SHALL have reset abort any in-flight state, with no partial update surviving.

Verification
REQ-034 SHALL verify the reset then rename sequence: rstn low 1 cycle; dispatch dr=5, sr1=5, dr_wr=1 -> sr1_p=5, dr_p=32, old_dr_p=5; next dispatch sr1=5 -> sr1_p=32; free_cnt=31.
REQ-035 SHALL verify exhaustion: 32 back-to-back allocating dispatches -> free_cnt=0; the 33rd gets disp_ready=0; a store (dr_wr=0) the same cycle gets disp_ready=1.
REQ-036 SHALL verify retire with no bypass: at free_cnt=0, retire ret_old=7 -> disp_ready stays 0 that cycle, next cycle dr_p=7 and free_cnt=1 before the allocation.
REQ-037 SHALL verify flush recovery: 4 allocations, retire 1, flush -> spec_rat equals arch_rat, free_cnt=FL-1, and the next dr_p equals the 2nd allocated preg.
REQ-038 SHALL verify dual retire plus flush in one cycle: both ports retire areg 3 with preg 40 then 41 -> arch_rat[3]=41 and spec_rat[3]=41 after flush.
REQ-039 SHALL verify that a write to x0 with dr=0 and dr_wr=1 -> dr_p=0, old_vld=0, and free_cnt unchanged.

Source files
------------

// File: rtl/reg_renamer.sv
// Register renamer: speculative and committed RATs over a circular free list of physical registers.
// Flush restores the speculative map and the allocation pointer from the committed state.
module reg_renamer #(
    parameter int unsigned ARCH_REGS = 32,
    parameter int unsigned PHYS_REGS = 64,
    parameter int unsigned RET_W     = 2,
    localparam int unsigned AW = $clog2(ARCH_REGS),
    localparam int unsigned PW = $clog2(PHYS_REGS),
    localparam int unsigned FL = PHYS_REGS - ARCH_REGS,
    localparam int unsigned CW = $clog2(FL) + 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                disp_valid,
    output logic                disp_ready,
    input  logic [AW-1:0]       sr1,
    input  logic [AW-1:0]       sr2,
    input  logic [AW-1:0]       dr,
    input  logic                dr_wr,
    output logic [PW-1:0]       sr1_p,
    output logic [PW-1:0]       sr2_p,
    output logic [PW-1:0]       dr_p,
    output logic [PW-1:0]       old_dr_p,
    output logic                old_vld,
    input  logic [RET_W-1:0]    ret_valid,
    input  logic [RET_W-1:0]    ret_alloc,
    input  logic [RET_W*AW-1:0] ret_areg,
    input  logic [RET_W*PW-1:0] ret_preg,
    input  logic [RET_W*PW-1:0] ret_old,
    input  logic                flush,
    output logic [CW-1:0]       free_cnt
);

    localparam int unsigned IW = CW - 1;

    logic [PW-1:0] spec_rat_q  [ARCH_REGS];
    logic [PW-1:0] arch_rat_q  [ARCH_REGS];
    logic [PW-1:0] arch_rat_d  [ARCH_REGS];
    logic [PW-1:0] free_list_q [FL];
    logic [PW-1:0] free_list_d [FL];
    logic [CW-1:0] head_q, tail_q, tail_d, commit_q, commit_d;
    logic          alloc, fire;

    assign alloc      = disp_valid & dr_wr & (dr != '0);
    assign free_cnt   = tail_q - head_q;
    assign disp_ready = rstn & ~flush & (~alloc | (free_cnt != '0));
    assign fire       = disp_valid & disp_ready & alloc;

    always_comb begin
        sr1_p    = spec_rat_q[sr1];
        sr2_p    = spec_rat_q[sr2];
        dr_p     = '0;
        old_dr_p = '0;
        old_vld  = 1'b0;
        if (alloc) begin
            dr_p     = free_list_q[head_q[IW-1:0]];
            old_dr_p = spec_rat_q[dr];
            old_vld  = 1'b1;
        end
    end

    // Retire ports in ascending order so a younger port overrides an older one on the same areg.
    always_comb begin
        arch_rat_d  = arch_rat_q;
        free_list_d = free_list_q;
        tail_d      = tail_q;
        commit_d    = commit_q;
        for (int k = 0; k < int'(RET_W); k++) begin
            if (ret_valid[k] && ret_alloc[k]) begin
                if (ret_areg[k*AW +: AW] != '0) begin
                    arch_rat_d[ret_areg[k*AW +: AW]] = ret_preg[k*PW +: PW];
                end
                commit_d = commit_d + 1'b1;
                if (ret_old[k*PW +: PW] != '0) begin
                    free_list_d[tail_d[IW-1:0]] = ret_old[k*PW +: PW];
                    tail_d = tail_d + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < int'(ARCH_REGS); i++) begin
                spec_rat_q[i] <= PW'(i);
                arch_rat_q[i] <= PW'(i);
            end
            for (int j = 0; j < int'(FL); j++) begin
                free_list_q[j] <= PW'(ARCH_REGS + j);
            end
            head_q   <= '0;
            commit_q <= '0;
            tail_q   <= CW'(FL);
        end else begin
            arch_rat_q  <= arch_rat_d;
            free_list_q <= free_list_d;
            tail_q      <= tail_d;
            commit_q    <= commit_d;
            if (flush) begin
                spec_rat_q <= arch_rat_d;
                head_q     <= commit_d;
            end else if (fire) begin
                spec_rat_q[dr] <= dr_p;
                head_q         <= head_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_renamer.sv
// Directed bench for reg_renamer: reset, rename, exhaustion, retire without bypass,
// flush recovery and dual-retire ordering.
module tb_reg_renamer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        disp_valid;
    logic        disp_ready;
    logic [4:0]  sr1, sr2, dr;
    logic        dr_wr;
    logic [5:0]  sr1_p, sr2_p, dr_p, old_dr_p;
    logic        old_vld;
    logic [1:0]  ret_valid, ret_alloc;
    logic [9:0]  ret_areg;
    logic [11:0] ret_preg, ret_old;
    logic        flush;
    logic [5:0]  free_cnt;

    int checks = 0;
    int errors = 0;

    reg_renamer dut (
        .clk        (clk),
        .rstn       (rstn),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready),
        .sr1        (sr1),
        .sr2        (sr2),
        .dr         (dr),
        .dr_wr      (dr_wr),
        .sr1_p      (sr1_p),
        .sr2_p      (sr2_p),
        .dr_p       (dr_p),
        .old_dr_p   (old_dr_p),
        .old_vld    (old_vld),
        .ret_valid  (ret_valid),
        .ret_alloc  (ret_alloc),
        .ret_areg   (ret_areg),
        .ret_preg   (ret_preg),
        .ret_old    (ret_old),
        .flush      (flush),
        .free_cnt   (free_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = 1'b0; dr_wr = 1'b0; sr1 = '0; sr2 = '0; dr = '0;
        ret_valid = '0; ret_alloc = '0; ret_areg = '0; ret_preg = '0; ret_old = '0;
        flush = 1'b0;
    endtask

    // Reset with an allocating dispatch pending, which must be refused.
    task automatic do_reset();
        idle();
        rstn = 1'b0; disp_valid = 1'b1; dr = 5'd5; dr_wr = 1'b1;
        #1;
        chk("rst_ready", disp_ready, 0);
        tick();
        rstn = 1'b1;
        idle();
        #1;
    endtask

    task automatic disp(input logic [4:0] d, input logic [4:0] s1);
        disp_valid = 1'b1; dr_wr = 1'b1; dr = d; sr1 = s1;
    endtask

    initial begin
        do_reset();
        chk("rst_free_cnt", free_cnt, 32);
        sr1 = 5'd7; sr2 = 5'd31; #1;
        chk("rst_sr1_p", sr1_p, 7);
        chk("rst_sr2_p", sr2_p, 31);

        // Basic rename: first allocation takes preg 32, source read sees pre-update mapping.
        disp(5'd5, 5'd5); #1;
        chk("ren_ready", disp_ready, 1);
        chk("ren_sr1_p", sr1_p, 5);
        chk("ren_dr_p", dr_p, 32);
        chk("ren_old_dr_p", old_dr_p, 5);
        chk("ren_old_vld", old_vld, 1);
        tick();
        disp(5'd6, 5'd5); #1;
        chk("ren2_sr1_p", sr1_p, 32);
        chk("ren2_free_cnt", free_cnt, 31);
        chk("ren2_dr_p", dr_p, 33);
        chk("ren2_old_dr_p", old_dr_p, 6);
        tick();
        chk("ren2_free_after", free_cnt, 30);

        // x0 destination never allocates.
        disp(5'd0, 5'd0); #1;
        chk("x0_dr_p", dr_p, 0);
        chk("x0_old_vld", old_vld, 0);
        chk("x0_ready", disp_ready, 1);
        tick();
        chk("x0_free_cnt", free_cnt, 30);

        // Store (no dr write) yields no allocation outputs.
        disp(5'd7, 5'd0); dr_wr = 1'b0; #1;
        chk("st_dr_p", dr_p, 0);
        chk("st_old_vld", old_vld, 0);
        tick();
        chk("st_free_cnt", free_cnt, 30);

        // Exhaustion.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            disp(5'((i % 31) + 1), 5'd0); #1;
            chk("exh_dr_p", dr_p, 32 + i);
            tick();
        end
        chk("exh_free_cnt", free_cnt, 0);
        disp(5'd1, 5'd0); #1;
        chk("exh_33_ready", disp_ready, 0);
        dr_wr = 1'b0; #1;
        chk("exh_store_ready", disp_ready, 1);

        // Retire into an empty list: freed preg is not usable until the next cycle.
        dr_wr = 1'b1; dr = 5'd2;
        ret_valid = 2'b01; ret_alloc = 2'b01;
        ret_areg = 10'd1; ret_preg = 12'd32; ret_old = 12'd7; #1;
        chk("nobyp_ready", disp_ready, 0);
        tick();
        ret_valid = '0; ret_alloc = '0; #1;
        chk("nobyp_free_cnt", free_cnt, 1);
        chk("nobyp_dr_p", dr_p, 7);
        chk("nobyp_ready_next", disp_ready, 1);
        disp_valid = 1'b0;

        // ret_valid without ret_alloc is a no-op.
        ret_valid = 2'b01; ret_alloc = 2'b00; ret_old = 12'd9;
        tick();
        idle(); #1;
        chk("noalloc_free_cnt", free_cnt, 1);

        // Flush recovery: allocations 32..35 to x1..x4, oldest one retires.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            disp(5'(i + 1), 5'd0);
            tick();
        end
        idle();
        chk("fl_pre_free_cnt", free_cnt, 28);
        // Old mapping of 0 is dropped, so only the committed allocation leaves the list.
        ret_valid = 2'b01; ret_alloc = 2'b01; ret_areg = 10'd1; ret_preg = 12'd32; ret_old = 12'd0;
        tick();
        idle();
        flush = 1'b1; #1;
        chk("fl_ready", disp_ready, 0);
        tick();
        idle(); #1;
        chk("fl_free_cnt", free_cnt, 31);
        sr1 = 5'd1; sr2 = 5'd2; #1;
        chk("fl_rat1", sr1_p, 32);
        chk("fl_rat2", sr2_p, 2);
        sr1 = 5'd3; sr2 = 5'd4; #1;
        chk("fl_rat3", sr1_p, 3);
        chk("fl_rat4", sr2_p, 4);
        disp(5'd8, 5'd0); #1;
        chk("fl_next_dr_p", dr_p, 33);
        disp_valid = 1'b0;

        // Dual retire of areg 3 with flush and an ignored dispatch in the same cycle.
        disp(5'd9, 5'd0);
        ret_valid = 2'b11; ret_alloc = 2'b11;
        ret_areg = {5'd3, 5'd3}; ret_preg = {6'd41, 6'd40}; ret_old = {6'd51, 6'd50};
        flush = 1'b1; #1;
        chk("dual_ready", disp_ready, 0);
        tick();
        idle();
        sr1 = 5'd3; sr2 = 5'd1; #1;
        chk("dual_rat3", sr1_p, 41);
        chk("dual_rat1", sr2_p, 32);
        chk("dual_free_cnt", free_cnt, 31);
        disp(5'd10, 5'd0); #1;
        chk("dual_next_dr_p", dr_p, 35);
        tick();
        idle();
        chk("dual_free_after", free_cnt, 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
